// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//   Data-side load/store unit sitting behind the instruction controller.
//   Takes the controller's mem_rd/mem_wr/mem_mode strobes together with the
//   ALU byte address and rs2 store data. It runs one req/ack transaction on
//   the data-memory bus, steers bytes into the right lanes, and returns a
//   sign/zero-extended load value to the writeback mux.
//
//   Access timeline: IDLE (request seen, stall) -> BUSY (bus_req, stall,
//   waits for ack) -> DONE (stall low, rdata valid, core commits) -> IDLE.
//
// Parameters
//   TIMEOUT : bus-wait cycles before the access is abandoned (0 = never)
//   ADDR_W  : byte-address width (must be > 2)
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   mem_rd, mem_wr       load / store request (both high = store)
//   mem_mode             00 byte, 01 half, 10/11 word
//   ld_unsigned          zero-extend byte/half loads
//   addr, wdata          byte address, store data
//   rdata                formatted load data (held until next capture)
//   stall                freeze PC / rf write while the access is in flight
//   bus_err              one-cycle pulse when an access times out
//   misalign_fault       one-cycle pulse on a trapped misaligned access
//   bus_req/we/addr/be/wdata, bus_rdata, bus_ack   data-memory bus
//
// Build option
//   LSU_MISALIGN_TRAP_EN : when defined, misaligned half/word accesses are
//   refused in IDLE with misalign_fault. When undefined, misalign_fault is
//   tied low and the low address bits a half/word access cannot use are
//   simply dropped.
// ---------------------------------------------------------------------------

// One byte lane of the store formatter: picks the source byte for this lane
// and decides whether the lane is enabled.
module lsu_store_lane #(
    parameter int LANE = 0
) (
    input  logic [1:0]  mode,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic        be,
    output logic [7:0]  data
);
    localparam logic [1:0] IDX = 2'(LANE);

    always_comb begin
        data = wdata[8*LANE +: 8];
        be   = 1'b1;
        case (mode)
            2'b00: begin
                // The low byte is replicated into every lane.
                data = wdata[7:0];
                be   = (addr_lo == IDX);
            end
            2'b01: begin
                // The low half is replicated into both halves; only addr[1] matters.
                data = wdata[8*(LANE%2) +: 8];
                be   = (addr_lo[1] == IDX[1]);
            end
            default: begin
                data = wdata[8*LANE +: 8];
                be   = 1'b1;
            end
        endcase
    end
endmodule

module load_store_unit #(
    parameter int TIMEOUT = 15,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [1:0]        mem_mode,
    input  logic              ld_unsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              stall,
    output logic              bus_err,
    output logic              misalign_fault,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_ack
);
    localparam int NUM_LANES = 4;
    localparam bit TO_EN     = (TIMEOUT > 0);
    localparam int CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // The wait counter starts at 0 in the first BUSY cycle, so the
    // TIMEOUT-th BUSY cycle without an ack is the one that sees CNT_LAST.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [1:0]       addr_q;
    logic [1:0]       mode_q;
    logic             uns_q;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      rdata_q;

    logic                             req;
    logic                             trap;
    logic                             accept;
    logic [NUM_LANES-1:0]             lane_be;
    logic [NUM_LANES-1:0][7:0]        lane_data;

    assign req = mem_rd | mem_wr;

`ifdef LSU_MISALIGN_TRAP_EN
    logic misaligned;
    always_comb begin
        case (mem_mode)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = addr[0];
            default: misaligned = |addr[1:0];
        endcase
    end
    assign trap = misaligned;
`else
    assign trap = 1'b0;
`endif

    assign accept         = (state == IDLE) && req && !trap;
    assign stall          = accept || (state == BUSY);
    assign misalign_fault = !rst && (state == IDLE) && req && trap;
    // A refused access must not present stale data to writeback.
    assign rdata          = misalign_fault ? 32'h0 : rdata_q;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        lsu_store_lane #(.LANE(g)) u_lane (
            .mode    (mem_mode),
            .addr_lo (addr[1:0]),
            .wdata   (wdata),
            .be      (lane_be[g]),
            .data    (lane_data[g])
        );
    end

    function automatic logic [31:0] fmt_load(
        input logic [31:0] w,
        input logic [1:0]  lo,
        input logic [1:0]  m,
        input logic        u
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*lo +: 8];
        h = lo[1] ? w[31:16] : w[15:0];
        case (m)
            2'b00:   return u ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   return u ? {16'h0, h} : {{16{h[15]}}, h};
            default: return w;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_err   <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
            rdata_q   <= '0;
            cnt       <= '0;
            addr_q    <= '0;
            mode_q    <= '0;
            uns_q     <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q    <= addr[1:0];
                        mode_q    <= mem_mode;
                        uns_q     <= ld_unsigned;
                        bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                        bus_be    <= lane_be;
                        bus_wdata <= lane_data;
                        bus_we    <= mem_wr;
                        bus_req   <= 1'b1;
                        cnt       <= '0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus_ack) begin
                        rdata_q <= bus_we ? 32'h0 : fmt_load(bus_rdata, addr_q, mode_q, uns_q);
                        bus_req <= 1'b0;
                        state   <= DONE;
                    end else if (TO_EN && (cnt == CNT_LAST)) begin
                        rdata_q <= 32'h0;
                        bus_err <= 1'b1;
                        bus_req <= 1'b0;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    // mem_rd/mem_wr are still high for the committing
                    // instruction; never restart from here.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_rd, mem_wr, ld_unsigned;
    logic [1:0]  mem_mode;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        stall, bus_err, misalign_fault;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata, bus_rdata;
    logic        bus_ack;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT(15), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_mode(mem_mode),
        .ld_unsigned(ld_unsigned), .addr(addr), .wdata(wdata),
        .rdata(rdata), .stall(stall), .bus_err(bus_err),
        .misalign_fault(misalign_fault),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts and ends at posedge+1 with the DUT in IDLE. The bus answers
    // with bus_ack in the (ack_after+1)-th bus_req cycle.
    task automatic run_access(
        input  logic        rd, wr,
        input  logic [1:0]  mode,
        input  logic        uns,
        input  logic [31:0] a, wd, rword,
        input  int          ack_after,
        output int          n_stall, n_req, n_err,
        output logic [31:0] o_rdata, o_addr, o_wdata,
        output logic [3:0]  o_be,
        output logic        o_we
    );
        logic done;
        mem_rd = rd; mem_wr = wr; mem_mode = mode; ld_unsigned = uns;
        addr = a; wdata = wd; bus_rdata = rword; bus_ack = 1'b0;
        n_stall = 0; n_req = 0; n_err = 0; done = 1'b0;
        o_rdata = 'x; o_addr = 'x; o_wdata = 'x; o_be = 'x; o_we = 1'bx;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (stall) n_stall++;
            if (bus_err) n_err++;
            if (bus_req) begin
                if (n_req == 0) begin
                    o_addr = bus_addr; o_wdata = bus_wdata; o_be = bus_be; o_we = bus_we;
                end
                n_req++;
                bus_ack = (n_req > ack_after);
            end else begin
                bus_ack = 1'b0;
            end
            if (!stall && n_stall > 0) begin
                done = 1'b1;
                o_rdata = rdata;
                break;
            end
            step();
        end
        chk("access_completes", {31'h0, done}, 32'h1);
        mem_rd = 1'b0; mem_wr = 1'b0; bus_ack = 1'b0;
        step();
    endtask

    int          ns, nr, ne;
    logic [31:0] r_rd, r_addr, r_wd;
    logic [3:0]  r_be;
    logic        r_we;

    initial begin
        rst = 1'b1; mem_rd = 0; mem_wr = 0; mem_mode = 0; ld_unsigned = 0;
        addr = 0; wdata = 0; bus_rdata = 0; bus_ack = 0;
        step(); step(); step();
        chk("rst_bus_req", {31'h0, bus_req}, 0);
        chk("rst_bus_we", {31'h0, bus_we}, 0);
        chk("rst_bus_err", {31'h0, bus_err}, 0);
        chk("rst_misalign", {31'h0, misalign_fault}, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_be", {28'h0, bus_be}, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_stall", {31'h0, stall}, 0);
        rst = 1'b0;
        step();

        // Word load, zero-wait ack
        run_access(1, 0, 2'b10, 0, 32'h100, 0, 32'hDEADBEEF, 0, ns, nr, ne, r_rd, r_addr, r_wd, r_be, r_we);
        chk("wl_stall_cycles", ns, 2);
        chk("wl_req_cycles", nr, 1);
        chk("wl_bus_addr", r_addr, 32'h100);
        chk("wl_bus_be", {28'h0, r_be}, 32'hF);
        chk("wl_bus_we", {31'h0, r_we}, 0);
        chk("wl_rdata", r_rd, 32'hDEADBEEF);
        chk("wl_rdata_hold", rdata, 32'hDEADBEEF);

        // bus_ack while idle does nothing
        bus_ack = 1'b1;
        step(); step();
        chk("idle_ack_req", {31'h0, bus_req}, 0);
        chk("idle_ack_stall", {31'h0, stall}, 0);
        chk("idle_ack_rdata", rdata, 32'hDEADBEEF);
        bus_ack = 1'b0;
        step();

        // Byte load signed / unsigned from lane 3
        run_access(1, 0, 2'b00, 0, 32'h103, 0, 32'h80FF1234, 0, ns, nr, ne, r_rd, r_addr, r_wd, r_be, r_we);
        chk("lb_rdata", r_rd, 32'hFFFFFF80);
        chk("lb_bus_addr", r_addr, 32'h100);
        chk("lb_bus_be", {28'h0, r_be}, 32'h8);
        run_access(1, 0, 2'b00, 1, 32'h103, 0, 32'h80FF1234, 0, ns, nr, ne, r_rd, r_addr, r_wd, r_be, r_we);
        chk("lbu_rdata", r_rd, 32'h00000080);

        // Half store to upper half
        run_access(0, 1, 2'b01, 0, 32'h206, 32'h0000ABCD, 32'h0, 0, ns, nr, ne, r_rd, r_addr, r_wd, r_be, r_we);
        chk("sh_bus_addr", r_addr, 32'h204);
        chk("sh_bus_be", {28'h0, r_be}, 32'hC);
        chk("sh_bus_wdata", r_wd, 32'hABCDABCD);
        chk("sh_bus_we", {31'h0, r_we}, 1);
        chk("sh_rdata", r_rd, 0);

        // Byte store to lane 1
        run_access(0, 1, 2'b00, 0, 32'h101, 32'h12345677, 32'h0, 0, ns, nr, ne, r_rd, r_addr, r_wd, r_be, r_we);
        chk("sb_bus_be", {28'h0, r_be}, 32'h2);
        chk("sb_bus_wdata", r_wd, 32'h77777777);

        // Half loads
        run_access(1, 0, 2'b01, 0, 32'h102, 0, 32'h80FF1234, 0, ns, nr, ne, r_rd, r_addr, r_wd, r_be, r_we);
        chk("lh_rdata", r_rd, 32'hFFFF80FF);
        run_access(1, 0, 2'b01, 1, 32'h100, 0, 32'h80FF1234, 0, ns, nr, ne, r_rd, r_addr, r_wd, r_be, r_we);
        chk("lhu_rdata", r_rd, 32'h00001234);

        // Two wait cycles
        run_access(1, 0, 2'b10, 0, 32'h10C, 0, 32'h11223344, 2, ns, nr, ne, r_rd, r_addr, r_wd, r_be, r_we);
        chk("wait2_stall_cycles", ns, 4);
        chk("wait2_req_cycles", nr, 3);
        chk("wait2_rdata", r_rd, 32'h11223344);

        // Timeout
        run_access(1, 0, 2'b10, 0, 32'h110, 0, 32'h55555555, 1000, ns, nr, ne, r_rd, r_addr, r_wd, r_be, r_we);
        chk("to_req_cycles", nr, 15);
        chk("to_err_pulses", ne, 1);
        chk("to_stall_cycles", ns, 16);
        chk("to_rdata", r_rd, 0);
        chk("to_err_cleared", {31'h0, bus_err}, 0);

        // rd and wr together is a store; mode 11 is a word
        run_access(1, 1, 2'b11, 0, 32'h300, 32'hCAFEF00D, 32'h0, 0, ns, nr, ne, r_rd, r_addr, r_wd, r_be, r_we);
        chk("rdwr_bus_we", {31'h0, r_we}, 1);
        chk("m11_bus_be", {28'h0, r_be}, 32'hF);
        chk("m11_bus_wdata", r_wd, 32'hCAFEF00D);

        // Reset in the third BUSY cycle
        mem_rd = 1; mem_mode = 2'b10; addr = 32'h400; bus_ack = 0;
        step(); step(); step();
        chk("rmid_busy_req", {31'h0, bus_req}, 1);
        rst = 1'b1; mem_rd = 0;
        step();
        chk("rmid_bus_req", {31'h0, bus_req}, 0);
        chk("rmid_stall", {31'h0, stall}, 0);
        chk("rmid_bus_be", {28'h0, bus_be}, 0);
        rst = 1'b0;
        step();
        run_access(1, 0, 2'b10, 0, 32'h404, 0, 32'h5A5A0001, 0, ns, nr, ne, r_rd, r_addr, r_wd, r_be, r_we);
        chk("rpost_stall_cycles", ns, 2);
        chk("rpost_rdata", r_rd, 32'h5A5A0001);

        // Misaligned word load
`ifdef LSU_MISALIGN_TRAP_EN
        mem_rd = 1; mem_mode = 2'b10; ld_unsigned = 0; addr = 32'h102;
        #1;
        chk("mis_fault", {31'h0, misalign_fault}, 1);
        chk("mis_stall", {31'h0, stall}, 0);
        chk("mis_rdata", rdata, 0);
        mem_rd = 0;
        step();
        chk("mis_no_req", {31'h0, bus_req}, 0);
        chk("mis_fault_clr", {31'h0, misalign_fault}, 0);
        chk("mis_rdata_back", rdata, 32'h5A5A0001);
`else
        run_access(1, 0, 2'b10, 0, 32'h102, 0, 32'h0BADF00D, 0, ns, nr, ne, r_rd, r_addr, r_wd, r_be, r_we);
        chk("mis_bus_addr", r_addr, 32'h100);
        chk("mis_stall_cycles", ns, 2);
        chk("mis_rdata", r_rd, 32'h0BADF00D);
        chk("mis_fault_tied", {31'h0, misalign_fault}, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
